// File: rtl/snes_pad_reader.sv
// Polls two SNES controllers at a fixed rate. Each frame latches both pads, clocks out
// 16 serial bits, then publishes active-high button words together with a one-cycle valid.
module snes_pad_reader #(
  parameter int HALF_CYC  = 300,
  parameter int LATCH_CYC = 600,
  parameter int POLL_CYC  = 833333
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pad_data_p1,
  input  logic        pad_data_p2,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [15:0] buttons_p1,
  output logic [15:0] buttons_p2,
  output logic        valid,
  output logic        busy
);

  localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int POLL_W    = $clog2(POLL_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [PHASE_W-1:0]  phase_reg, phase_next;
  logic [3:0]          idx_reg, idx_next;
  logic [POLL_W-1:0]   poll_reg;
  logic [15:0]         raw_p1_reg, raw_p2_reg;
  logic                poll_tick;
  logic                sample_en;

  assign poll_tick = (poll_reg == POLL_W'(POLL_CYC - 1));
  // Pad data is stable by the first low cycle; it last changed on the previous rising pad_clk.
  assign sample_en = (state_reg == CLK_LO) && (phase_reg == '0);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg + PHASE_W'(1);
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        phase_next = '0;
        if (poll_tick) state_next = LATCH;
      end
      LATCH: begin
        if (phase_reg == PHASE_W'(LATCH_CYC - 1)) begin
          state_next = CLK_LO;
          phase_next = '0;
          idx_next   = '0;
        end
      end
      CLK_LO: begin
        if (phase_reg == PHASE_W'(HALF_CYC - 1)) begin
          state_next = CLK_HI;
          phase_next = '0;
        end
      end
      CLK_HI: begin
        if (phase_reg == PHASE_W'(HALF_CYC - 1)) begin
          phase_next = '0;
          if (idx_reg == 4'd15) begin
            state_next = DONE;
          end else begin
            state_next = CLK_LO;
            idx_next   = idx_reg + 4'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        phase_next = '0;
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      idx_reg    <= '0;
      poll_reg   <= '0;
      raw_p1_reg <= 16'hFFFF;
      raw_p2_reg <= 16'hFFFF;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b1;
      busy       <= 1'b0;
      valid      <= 1'b0;
      buttons_p1 <= 16'h0000;
      buttons_p2 <= 16'h0000;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      idx_reg   <= idx_next;
      poll_reg  <= poll_tick ? '0 : poll_reg + POLL_W'(1);
      if (sample_en) begin
        raw_p1_reg[idx_reg] <= pad_data_p1;
        raw_p2_reg[idx_reg] <= pad_data_p2;
      end
      // Pin outputs follow the next state so they are registered yet aligned with state_reg.
      pad_latch <= (state_next == LATCH);
      pad_clk   <= (state_next != CLK_LO);
      busy      <= (state_next != IDLE);
      valid     <= (state_reg == DONE);
      if (state_reg == DONE) begin
        buttons_p1 <= ~raw_p1_reg;
        buttons_p2 <= ~raw_p2_reg;
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: behavioural pads, a cycle-timeline model of the frame
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_snes_pad_reader;

  localparam int HALF  = 2;
  localparam int LATCH = 4;
  localparam int POLL  = 100;
  localparam int FRAME = LATCH + 32 * HALF + 1;   // 69 busy cycles

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pad_data_p1, pad_data_p2;
  logic        pad_latch, pad_clk, valid, busy;
  logic [15:0] buttons_p1, buttons_p2;

  logic [15:0] pat1 = 16'hA5C3;
  logic [15:0] pat2 = 16'h0000;
  logic [15:0] sr1 = 16'hFFFF;
  logic [15:0] sr2 = 16'hFFFF;

  int tests = 0;
  int fails = 0;

  snes_pad_reader #(.HALF_CYC(HALF), .LATCH_CYC(LATCH), .POLL_CYC(POLL)) dut (
    .clock(clock), .reset(reset),
    .pad_data_p1(pad_data_p1), .pad_data_p2(pad_data_p2),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .buttons_p1(buttons_p1), .buttons_p2(buttons_p2),
    .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // Pad: parallel load while latched (active-low), shift on each pad_clk rise.
  assign pad_data_p1 = sr1[0];
  assign pad_data_p2 = sr2[0];
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      sr1 <= ~pat1;
      sr2 <= ~pat2;
    end else begin
      sr1 <= {1'b1, sr1[15:1]};
      sr2 <= {1'b1, sr2[15:1]};
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Timeline model: t = edges since reset release; frames start where t is a nonzero multiple of POLL.
  int          t = 0;
  bit          started = 1'b0;
  logic [15:0] snap1, snap2, exp_b1, exp_b2;

  always @(posedge clock) begin
    if (reset) begin
      t = 0;
      started = 1'b1;
      exp_b1 = 16'h0;
      exp_b2 = 16'h0;
    end else if (started) begin
      t++;
      if (t >= POLL && t % POLL == 0) begin
        snap1 = pat1;
        snap2 = pat2;
      end
      if (t >= POLL && t % POLL == FRAME) begin
        exp_b1 = snap1;
        exp_b2 = snap2;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      int  o;
      bit  act;
      logic e_latch, e_clk, e_busy, e_valid;
      o   = t % POLL;
      act = (t >= POLL);
      e_latch = act && o < LATCH;
      e_busy  = act && o < FRAME;
      e_clk   = !(act && o >= LATCH && o < FRAME - 1 && ((o - LATCH) % (2 * HALF)) < HALF);
      e_valid = act && o == FRAME;
      check("model pad_latch", {15'b0, pad_latch}, {15'b0, e_latch});
      check("model pad_clk",   {15'b0, pad_clk},   {15'b0, e_clk});
      check("model busy",      {15'b0, busy},      {15'b0, e_busy});
      check("model valid",     {15'b0, valid},     {15'b0, e_valid});
      check("model buttons_p1", buttons_p1, exp_b1);
      check("model buttons_p2", buttons_p2, exp_b2);
    end
  end

  task automatic run(input int n, output int n_valid, output int valid_at, output int first_latch);
    n_valid = 0;
    valid_at = -1;
    first_latch = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (valid) begin
        n_valid++;
        valid_at = t;
      end
      if (pad_latch && first_latch < 0) first_latch = i;
    end
  endtask

  initial begin
    int nv, vat, fl, prev_valid;
    int latch_cnt, busy_cnt, falls, low_total, low_run, high_run, bad_runs;
    logic prev_clk;

    repeat (3) @(negedge clock);
    check("reset pad_clk",    {15'b0, pad_clk},   16'h1);
    check("reset pad_latch",  {15'b0, pad_latch}, 16'h0);
    check("reset busy",       {15'b0, busy},      16'h0);
    check("reset valid",      {15'b0, valid},     16'h0);
    check("reset buttons_p1", buttons_p1, 16'h0);
    check("reset buttons_p2", buttons_p2, 16'h0);
    reset = 1'b0;

    // Frame 1 with detailed timing measurement.
    latch_cnt = 0; busy_cnt = 0; falls = 0; low_total = 0;
    low_run = 0; high_run = 0; bad_runs = 0; nv = 0; vat = -1; fl = -1;
    prev_clk = 1'b1;
    for (int i = 1; i <= 170; i++) begin
      @(negedge clock);
      if (pad_latch) begin
        latch_cnt++;
        if (fl < 0) fl = i;
      end
      if (busy) busy_cnt++;
      if (valid) begin nv++; vat = i; end
      if (!pad_clk) begin
        if (prev_clk) begin
          falls++;
          if (falls > 1 && high_run != HALF) bad_runs++;
        end
        low_run++;
        low_total++;
        high_run = 0;
      end else begin
        if (!prev_clk && low_run != HALF) bad_runs++;
        low_run = 0;
        high_run++;
      end
      prev_clk = pad_clk;
    end
    check("first latch cycle", 16'(fl), 16'd100);
    check("latch high cycles", 16'(latch_cnt), 16'd4);
    check("busy cycles", 16'(busy_cnt), 16'd69);
    check("pad_clk falls", 16'(falls), 16'd16);
    check("pad_clk low cycles", 16'(low_total), 16'd32);
    check("pad_clk run widths", 16'(bad_runs), 16'd0);
    check("frame1 valid count", 16'(nv), 16'd1);
    check("frame1 valid cycle", 16'(vat), 16'd169);
    check("frame1 buttons_p1", buttons_p1, 16'hA5C3);
    check("frame1 buttons_p2", buttons_p2, 16'h0000);
    prev_valid = vat;

    // Change patterns while idle; words must hold until the next valid.
    pat1 = 16'h1234;
    pat2 = 16'hFFFF;
    run(29, nv, vat, fl);
    check("hold buttons_p1", buttons_p1, 16'hA5C3);
    check("hold buttons_p2", buttons_p2, 16'h0000);
    check("hold no valid", 16'(nv), 16'd0);
    run(71, nv, vat, fl);
    check("frame2 valid count", 16'(nv), 16'd1);
    check("valid spacing", 16'(vat - prev_valid), 16'd100);
    check("frame2 buttons_p1", buttons_p1, 16'h1234);
    check("frame2 buttons_p2", buttons_p2, 16'hFFFF);

    // Abort frame 3 during bit 7 (low phase of bit 7 begins at t=332).
    run(62, nv, vat, fl);
    check("pre-abort pad_clk low", {15'b0, pad_clk}, 16'h0);
    reset = 1'b1;
    @(negedge clock);
    check("abort pad_clk",    {15'b0, pad_clk},   16'h1);
    check("abort pad_latch",  {15'b0, pad_latch}, 16'h0);
    check("abort busy",       {15'b0, busy},      16'h0);
    check("abort valid",      {15'b0, valid},     16'h0);
    check("abort buttons_p1", buttons_p1, 16'h0);
    check("abort buttons_p2", buttons_p2, 16'h0);
    reset = 1'b0;
    pat1 = 16'h8001;
    pat2 = 16'h7FFE;
    run(170, nv, vat, fl);
    check("post-abort first latch", 16'(fl), 16'd100);
    check("post-abort valid count", 16'(nv), 16'd1);
    check("post-abort buttons_p1", buttons_p1, 16'h8001);
    check("post-abort buttons_p2", buttons_p2, 16'h7FFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snes_pad_reader.md
SNES_PAD_READER -- requirements
Module: snes_pad_reader

Interface
REQ-001 Parameter HALF_CYC, default 300: clock cycles per pad_clk half-period (6 us at 50 MHz).
REQ-002 Parameter LATCH_CYC, default 600: clock cycles pad_latch is held high.
REQ-003 Parameter POLL_CYC, default 833333: clock cycles between frame starts (60 Hz); constraint POLL_CYC >= LATCH_CYC + 32*HALF_CYC + 2.
REQ-004 clock  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pad_data_p1  in  1  player-1 serial data, active-low (0 = pressed).
REQ-007 pad_data_p2  in  1  player-2 serial data, active-low.
REQ-008 pad_latch  out  1  latch strobe shared by both pads, active-high.
REQ-009 pad_clk  out  1  shift clock shared by both pads, idles high.
REQ-010 buttons_p1  out  16  player-1 button word, 1 = pressed; bit i = i-th serial bit.
REQ-011 buttons_p2  out  16  player-2 button word, same encoding.
REQ-012 valid  out  1  one-cycle pulse when button words update.
REQ-013 busy  out  1  high while a frame is in progress.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 Free-running poll counter SHALL count 0..POLL_CYC-1 and wrap; the wrap cycle is the poll tick.
REQ-016 FSM states SHALL be IDLE, LATCH, CLK_LO, CLK_HI, DONE.
REQ-017 IDLE: pad_latch=0, pad_clk=1, busy=0; on poll tick -> LATCH.
REQ-018 LATCH: pad_latch=1, busy=1 for exactly LATCH_CYC cycles, then -> CLK_LO with bit index 0.
REQ-019 CLK_LO: pad_clk=0 for HALF_CYC cycles; in its first cycle both data inputs SHALL be sampled into raw shift bit [index].
REQ-020 CLK_HI: pad_clk=1 for HALF_CYC cycles; at end, index 15 -> DONE, else index+1 -> CLK_LO.
REQ-021 DONE: exactly one cycle; on exit buttons_p1 <= ~raw_p1, buttons_p2 <= ~raw_p2, and valid high for exactly that following cycle; -> IDLE.
REQ-022 Frame length (busy high) SHALL be LATCH_CYC + 32*HALF_CYC + 1 cycles; exactly 16 pad_clk falling edges per frame.
REQ-023 Button words SHALL hold their value between valid pulses regardless of pad_data activity.
REQ-024 A poll tick arriving while not IDLE SHALL be ignored, with no queuing; the parameter constraint prevents this case in legal configurations.
REQ-025 Bit-index counter SHALL be 4 bits and half/latch counters SHALL be wide enough for max(LATCH_CYC, HALF_CYC); no wrap within a phase.

Reset
REQ-026 On reset: state IDLE, pad_latch=0, pad_clk=1, buttons_p1=buttons_p2=0, valid=0, busy=0, poll counter=0, index=0, raw shift registers=16'hFFFF.
REQ-027 Reset asserted mid-frame SHALL abort the frame at the next edge, with no valid pulse and no button update; the first frame after release starts at the next poll tick.

Verification (bench params HALF_CYC=2, LATCH_CYC=4, POLL_CYC=100)
REQ-028 Reset for 3 cycles -> pad_clk=1, pad_latch=0, buttons 0, valid=0, busy=0; first pad_latch rise 100 cycles after reset release.
REQ-029 Shift-register pad models driving pressed pattern p1=16'hA5C3, p2=16'h0000 -> after frame buttons_p1=16'hA5C3, buttons_p2=16'h0000, single valid pulse.
REQ-030 Timing check -> pad_latch high exactly 4 cycles, 16 pad_clk low pulses of 2 cycles each separated by 2 high cycles, busy high 69 cycles.
REQ-031 Reset asserted during bit 7 -> next edge pad_clk=1, pad_latch=0, busy=0, buttons 0, no valid; next frame runs normally.
REQ-032 Change pad patterns while IDLE -> buttons unchanged until next valid; consecutive valid pulses exactly 100 cycles apart.
